// File: rtl/detector_jogada_pkg.sv
// Shared game constants for the key-input stage: FSM state codes and default sizes.
package detector_jogada_pkg;

    localparam int WIDTH_DEF           = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ESTABILIZA    = 2'd1,
        REGISTRA      = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

endpackage

// File: rtl/detector_jogada_contador_debounce.sv
// Debounce counter: synchronous clear wins over enable; fim flags the last count before wrap.
module contador_debounce #(
    parameter int MODULO = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic conta,
    output logic fim
);

    localparam int CNT_W = (MODULO > 2) ? $clog2(MODULO) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (limpa) begin
            cnt <= '0;
        end else if (conta) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign fim = (cnt == CNT_W'(MODULO - 1));

endmodule

// File: rtl/detector_jogada.sv
// Key-play detector: debounces chaves, emits one jogada_feita per press, waits for full release.
// Optional JOGADA_ONE_HOT_EN rejects multi-key plays via a one-cycle invalida strobe.
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int WIDTH           = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] chaves,
    input  logic             habilita,
    output logic [WIDTH-1:0] jogada,
    output logic             jogada_feita,
    output logic             invalida,
    output logic [3:0]       db_estado
);

    estado_t          estado;
    logic [WIDTH-1:0] amostra;
    logic             chaves_zero;
    logic             iguais;
    logic             aceita;
    logic             cnt_conta;
    logic             cnt_limpa;
    logic             fim;

    assign chaves_zero = (chaves == '0);
    assign iguais      = (chaves == amostra);

`ifdef JOGADA_ONE_HOT_EN
    // amostra is never zero when this is consulted, so a single set bit is all we need to test
    assign aceita = ((amostra & (amostra - WIDTH'(1))) == '0);
`else
    assign aceita = 1'b1;
`endif

    // Counter only advances while a stable value (press or release) is being timed
    always_comb begin
        cnt_conta = 1'b0;
        case (estado)
            ESTABILIZA:    cnt_conta = habilita && !chaves_zero && iguais && !fim;
            ESPERA_SOLTAR: cnt_conta = chaves_zero && !fim;
            default:       cnt_conta = 1'b0;
        endcase
        cnt_limpa = !cnt_conta;
    end

    contador_debounce #(
        .MODULO(DEBOUNCE_CYCLES)
    ) u_contador (
        .clock(clock),
        .reset(reset),
        .limpa(cnt_limpa),
        .conta(cnt_conta),
        .fim  (fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            amostra      <= '0;
            jogada       <= '0;
            jogada_feita <= 1'b0;
            invalida     <= 1'b0;
        end else begin
            jogada_feita <= 1'b0;
            invalida     <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (habilita && !chaves_zero) begin
                        estado  <= ESTABILIZA;
                        amostra <= chaves;
                    end
                end
                ESTABILIZA: begin
                    if (!habilita || chaves_zero) begin
                        estado <= OCIOSO;
                    end else if (!iguais) begin
                        amostra <= chaves;
                    end else if (fim) begin
                        // Strobes are set on entry so they are high exactly during REGISTRA
                        estado <= REGISTRA;
                        if (aceita) begin
                            jogada       <= amostra;
                            jogada_feita <= 1'b1;
                        end else begin
                            invalida <= 1'b1;
                        end
                    end
                end
                REGISTRA: begin
                    estado <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    if (chaves_zero && fim) begin
                        estado <= OCIOSO;
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign db_estado = {2'b00, estado};

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: expected strobes (cycle, kind, value) queued at stimulus time.
module tb_detector_jogada;

    logic       clock;
    logic       reset;
    logic [3:0] chaves;
    logic       habilita;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       invalida;
    logic [3:0] db_estado;

    typedef struct {
        int unsigned ciclo;
        logic        inval;
        logic [3:0]  valor;
    } esperado_t;

    esperado_t   sb[$];
    int unsigned cyc;
    int          n_tests;
    int          n_fail;

    detector_jogada #(
        .DEBOUNCE_CYCLES(4),
        .WIDTH          (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .chaves      (chaves),
        .habilita    (habilita),
        .jogada      (jogada),
        .jogada_feita(jogada_feita),
        .invalida    (invalida),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive chaves at n consecutive falling edges
    task automatic hold(input logic [3:0] valor, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chaves = valor;
        end
    endtask

    // First sampling edge is the next rising edge; REGISTRA is entered four edges after it
    task automatic expect_play(input logic [3:0] valor, input logic inval);
        esperado_t e;
        e.ciclo = cyc + 5;
        e.inval = inval;
        e.valor = valor;
        sb.push_back(e);
    endtask

    always @(negedge clock) begin
        esperado_t e;
        if (sb.size() != 0 && cyc > sb[0].ciclo) begin
            check_eq("missed_pulse", cyc, sb[0].ciclo);
            void'(sb.pop_front());
        end
        if (jogada_feita || invalida) begin
            if (sb.size() == 0) begin
                check_eq("spurious_pulse", {30'b0, jogada_feita, invalida}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("pulse_cycle", cyc, e.ciclo);
                check_eq("pulse_kind", {30'b0, jogada_feita, invalida}, e.inval ? 32'd1 : 32'd2);
                check_eq("pulse_jogada", {28'b0, jogada}, {28'b0, e.valor});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        chaves   = 4'b0000;
        habilita = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_estado", {28'b0, db_estado}, 32'd0);
        check_eq("rst_jogada", {28'b0, jogada}, 32'd0);
        check_eq("rst_strobes", {30'b0, jogada_feita, invalida}, 32'd0);
        reset    = 1'b1;
        habilita = 1'b1;
        hold(4'b0000, 2);

        // Long hold: one pulse only, no repeat until release
        @(negedge clock);
        chaves = 4'b0001;
        expect_play(4'b0001, 1'b0);
        hold(4'b0001, 10);
        hold(4'b0000, 6);
        check_eq("idle_after_release", {28'b0, db_estado}, 32'd0);

        // Bounce through zero: timing restarts from the final press
        hold(4'b0010, 2);
        hold(4'b0000, 1);
        @(negedge clock);
        chaves = 4'b0010;
        expect_play(4'b0010, 1'b0);
        hold(4'b0010, 10);
        hold(4'b0000, 6);

        // Value change mid-debounce restarts with the new value
        hold(4'b0010, 2);
        @(negedge clock);
        chaves = 4'b0100;
        expect_play(4'b0100, 1'b0);
        hold(4'b0100, 10);

        // Release glitch and early re-press stay in ESPERA_SOLTAR
        hold(4'b0000, 2);
        hold(4'b0100, 1);
        hold(4'b0000, 3);
        hold(4'b0100, 6);
        check_eq("blocked_until_release", {28'b0, db_estado}, 32'd3);
        hold(4'b0000, 3);
        @(negedge clock);
        check_eq("release_3_zeros", {28'b0, db_estado}, 32'd3);
        chaves = 4'b0000;
        @(negedge clock);
        check_eq("release_4_zeros", {28'b0, db_estado}, 32'd0);
        chaves = 4'b0010;
        expect_play(4'b0010, 1'b0);
        hold(4'b0010, 8);
        hold(4'b0000, 6);

        // habilita low: key ignored until enabled
        @(negedge clock);
        habilita = 1'b0;
        chaves   = 4'b1000;
        hold(4'b1000, 8);
        check_eq("disabled_idle", {28'b0, db_estado}, 32'd0);
        @(negedge clock);
        habilita = 1'b1;
        expect_play(4'b1000, 1'b0);
        hold(4'b1000, 8);
        hold(4'b0000, 6);

        // Multi-key play
        @(negedge clock);
        chaves = 4'b0011;
`ifdef JOGADA_ONE_HOT_EN
        expect_play(4'b1000, 1'b1);
`else
        expect_play(4'b0011, 1'b0);
`endif
        hold(4'b0011, 8);
        hold(4'b0000, 6);

        // Asynchronous reset in the middle of ESTABILIZA
        @(negedge clock);
        chaves = 4'b0010;
        @(negedge clock);
        check_eq("in_estabiliza", {28'b0, db_estado}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check_eq("async_rst_estado", {28'b0, db_estado}, 32'd0);
        check_eq("async_rst_jogada", {28'b0, jogada}, 32'd0);
        check_eq("async_rst_strobes", {30'b0, jogada_feita, invalida}, 32'd0);
        @(negedge clock);
        reset  = 1'b1;
        chaves = 4'b0000;
        hold(4'b0000, 3);
        check_eq("post_rst_estado", {28'b0, db_estado}, 32'd0);

        @(negedge clock);
        check_eq("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
